multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Control FSM plus ALU decoder for the multi-cycle RV32I core. Sits directly upstream
//  of the datapath and drives all of its mux selects and write enables from the opcode
//  fields of the latched instruction and the ALU Zero flag.
//  Supports lw, sw, R-type, I-type ALU, beq and jal. Can stall on a memory ready
//  handshake and traps on illegal encodings.
// PARAMETERS
//  USE_MEM_READY    1  1: FETCH/MEMREAD/MEMWRITE wait for mem_ready; 0: mem_ready ignored, treated as 1
//  TRAP_ON_ILLEGAL  1  1: illegal instruction -> ILLEGAL (sticky); 0: illegal -> FETCH (skip)
// PORTS
//  clk         in   1  clock, rising edge
//  reset       in   1  asynchronous, active-low reset
//  op          in   7  Instr[6:0] of latched instruction
//  funct3      in   3  Instr[14:12]
//  funct7b5    in   1  Instr[30]
//  Zero        in   1  ALU zero flag
//  mem_ready   in   1  memory completes the current access this cycle
//  PCWrite     out  1  PC register enable (= PCUpdate | (Branch & Zero))
//  AdrSrc      out  1  memory address: 0 = PC, 1 = Result
//  MemWrite    out  1  memory write strobe
//  IRWrite     out  1  instruction / OldPC register enable
//  RegWrite    out  1  register file write enable
//  ResultSrc   out  2  00 = ALUOut (registered), 01 = Data, 10 = ALUResult
//  ALUSrcA     out  2  00 = PC, 01 = OldPC, 10 = rd1 register
//  ALUSrcB     out  2  00 = rd2 register, 01 = ImmExt, 10 = constant 4
//  ImmSrc      out  2  00 = I, 01 = S, 10 = B, 11 = J (combinational from op)
//  ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
//  illegal     out  1  high while in ILLEGAL
//  state       out  4  current state encoding, for debug
// BEHAVIOUR
//  - Moore FSM; outputs decode from the state register only, except PCWrite (uses Zero),
//    ImmSrc/ALUControl (use instr fields), and the mem_ready qualification below.
//  - reset low: state = FETCH immediately (async). PCWrite, IRWrite, MemWrite and RegWrite
//    are forced 0 while reset is low. Reset mid-instruction abandons it; no partial write.
//  - Unlisted outputs are 0 / 00. ALUOp: 00 = add, 01 = sub, 10 = funct decode.
//  - State outputs (A = ALUSrcA, B = ALUSrcB, R = ResultSrc) and next state:
//    FETCH    AdrSrc=0, A=00, B=10, ALUOp=00, R=10.
//             If mem_ready: IRWrite=1, PCUpdate=1, next = DECODE. Otherwise hold.
//    DECODE   A=01, B=01, ALUOp=00 (branch target into ALUOut). Next by op:
//             0000011/0100011 -> MEMADR; 0110011 -> EXECUTER; 0010011 -> EXECUTEI;
//             1100011 -> BEQ; 1101111 -> JAL; anything else -> illegal path.
//    MEMADR   A=10, B=01, ALUOp=00. Next: MEMREAD if op[5]=0, MEMWRITE if op[5]=1.
//    MEMREAD  AdrSrc=1, R=00. If mem_ready, next = MEMWB; otherwise hold.
//    MEMWB    R=01, RegWrite=1. Next = FETCH.
//    MEMWRITE AdrSrc=1, R=00, MemWrite=1. MemWrite is held until mem_ready; then next = FETCH.
//    EXECUTER A=10, B=00, ALUOp=10. Next = ALUWB.
//    EXECUTEI A=10, B=01, ALUOp=10. Next = ALUWB.
//    ALUWB    R=00, RegWrite=1. Next = FETCH.
//    BEQ      A=10, B=00, ALUOp=01, R=00, Branch=1 (PCWrite=Zero). Next = FETCH.
//    JAL      A=01, B=10, ALUOp=00, R=00, PCUpdate=1. Next = ALUWB (rd <- PC+4).
//    ILLEGAL  All enables 0, illegal=1. Exits only on reset.
//  - ALU decode for ALUOp=10, by funct3:
//    000: sub if (op[5] & funct7b5), else add.  010: slt.  110: or.  111: and.
//    Any other funct3 on R/I-type is illegal. This is detected in DECODE.
//  - ImmSrc by op: sw -> 01, beq -> 10, jal -> 11, otherwise 00.
//  - Latency (mem_ready tied 1): lw 5, sw 4, R/I 4, beq 3, jal 4 cycles.
// TESTING
//  1. Hold reset low, then release; mem_ready=1 -> state=FETCH, IRWrite=1, PCWrite=1, ALUSrcB=10, R=10.
//  2. lw (op=0000011), mem_ready=1 -> FETCH,DECODE,MEMADR,MEMREAD,MEMWB; RegWrite=1 only in MEMWB, R=01.
//  3. sw, mem_ready low 3 cycles in MEMWRITE -> MemWrite=1 for 4 cycles; then FETCH; RegWrite never 1.
//  4. beq with Zero=1 then Zero=0 -> PCWrite=1 in BEQ only when Zero=1; ALUControl=001.
//  5. R-type sub (funct3=000, funct7b5=1) -> ALUControl=001; funct3=011 -> ILLEGAL, illegal=1 until reset.
//  6. Reset asserted while in MEMWRITE -> MemWrite drops same cycle; state=FETCH after release.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// Control bundle between the multi-cycle RV32I controller and its datapath.
// The controller owns the master side: it reads instruction fields and status, and drives every select and enable.
interface multicycle_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       mem_ready;

  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ImmSrc;
  logic [2:0] ALUControl;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  op, funct3, funct7b5, Zero, mem_ready,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal, state
  );

  modport slave (
    output op, funct3, funct7b5, Zero, mem_ready,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal, state
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM and ALU decoder (lw, sw, R/I ALU, beq, jal).
// Moore outputs from the state register; PCWrite, ImmSrc and ALUControl also look at Zero and the instruction fields.
module multicycle_controller #(
  parameter bit USE_MEM_READY   = 1'b1,
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset,
  multicycle_controller_if.master       bus
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10,
    ILLEGAL  = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  state_t     state_q, state_d;
  logic       mem_ok;
  logic       pc_update, branch, mem_write, ir_write, reg_write, adr_src, illegal_st;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
  state_t     bad_target;

  function automatic logic funct3_ok(input logic [2:0] f3);
    return (f3 == 3'b000) || (f3 == 3'b010) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

  function automatic logic [2:0] alu_decode(input logic [1:0] aop, input logic [2:0] f3,
                                            input logic op5, input logic f7b5);
    logic [2:0] ctl;
    ctl = 3'b000;
    case (aop)
      2'b01: ctl = 3'b001;
      2'b10: begin
        case (f3)
          3'b000:  ctl = (op5 & f7b5) ? 3'b001 : 3'b000;
          3'b010:  ctl = 3'b101;
          3'b110:  ctl = 3'b011;
          3'b111:  ctl = 3'b010;
          default: ctl = 3'b000;
        endcase
      end
      default: ctl = 3'b000;
    endcase
    return ctl;
  endfunction

  assign mem_ok     = USE_MEM_READY ? bus.mem_ready : 1'b1;
  assign bad_target = TRAP_ON_ILLEGAL ? ILLEGAL : FETCH;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    pc_update  = 1'b0;
    branch     = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    adr_src    = 1'b0;
    illegal_st = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    case (state_q)
      FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        if (mem_ok) begin
          ir_write  = 1'b1;
          pc_update = 1'b1;
          state_d   = DECODE;
        end
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        // Unsupported funct3 on ALU ops is caught here so EXECUTE never sees it
        case (bus.op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = funct3_ok(bus.funct3) ? EXECUTER : bad_target;
          OP_I:         state_d = funct3_ok(bus.funct3) ? EXECUTEI : bad_target;
          OP_BEQ:       state_d = BEQ;
          OP_JAL:       state_d = JAL;
          default:      state_d = bad_target;
        endcase
      end
      MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = bus.op[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        adr_src = 1'b1;
        if (mem_ok) state_d = MEMWB;
      end
      MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        state_d    = FETCH;
      end
      MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (mem_ok) state_d = FETCH;
      end
      EXECUTER: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        state_d   = ALUWB;
      end
      EXECUTEI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        state_d   = ALUWB;
      end
      ALUWB: begin
        reg_write = 1'b1;
        state_d   = FETCH;
      end
      BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
        state_d   = FETCH;
      end
      JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
        state_d   = ALUWB;
      end
      ILLEGAL: begin
        illegal_st = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end

  // Write enables are gated by reset so nothing commits while it is held low
  assign bus.PCWrite    = reset & (pc_update | (branch & bus.Zero));
  assign bus.IRWrite    = reset & ir_write;
  assign bus.MemWrite   = reset & mem_write;
  assign bus.RegWrite   = reset & reg_write;
  assign bus.AdrSrc     = adr_src;
  assign bus.ResultSrc  = result_src;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.illegal    = illegal_st;
  assign bus.state      = state_q;
  assign bus.ALUControl = alu_decode(alu_op, bus.funct3, bus.op[5], bus.funct7b5);
  assign bus.ImmSrc     = (bus.op == OP_SW)  ? 2'b01 :
                          (bus.op == OP_BEQ) ? 2'b10 :
                          (bus.op == OP_JAL) ? 2'b11 : 2'b00;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class through its states
// and checks selects, enables, stalls, trap and reset behaviour against hand-derived values.
module tb_multicycle_controller;
  logic clk;
  logic reset;
  int   errors;
  int   checks;

  multicycle_controller_if bus();

  multicycle_controller #(.USE_MEM_READY(1'b1), .TRAP_ON_ILLEGAL(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    reset         = 1'b0;
    bus.op        = 7'b0;
    bus.funct3    = 3'b0;
    bus.funct7b5  = 1'b0;
    bus.Zero      = 1'b0;
    bus.mem_ready = 1'b1;

    // reset held low: FETCH, enables forced off
    repeat (2) @(posedge clk);
    #2;
    check("rst_state",    32'(bus.state),    0);
    check("rst_irwrite",  32'(bus.IRWrite),  0);
    check("rst_pcwrite",  32'(bus.PCWrite),  0);
    check("rst_memwrite", 32'(bus.MemWrite), 0);
    check("rst_regwrite", 32'(bus.RegWrite), 0);

    @(negedge clk) reset = 1'b1;
    #1;
    check("fetch_state",   32'(bus.state),     0);
    check("fetch_irwrite", 32'(bus.IRWrite),   1);
    check("fetch_pcwrite", 32'(bus.PCWrite),   1);
    check("fetch_srcb",    32'(bus.ALUSrcB),   2);
    check("fetch_res",     32'(bus.ResultSrc), 2);
    check("fetch_adr",     32'(bus.AdrSrc),    0);

    // fetch stall
    bus.mem_ready = 1'b0;
    #1;
    check("stall_irwrite", 32'(bus.IRWrite), 0);
    check("stall_pcwrite", 32'(bus.PCWrite), 0);
    tick();
    check("stall_state", 32'(bus.state), 0);

    // lw
    bus.mem_ready = 1'b1;
    bus.op        = 7'b0000011;
    tick();
    check("lw_decode",   32'(bus.state),   1);
    check("lw_dec_srca", 32'(bus.ALUSrcA), 1);
    check("lw_dec_srcb", 32'(bus.ALUSrcB), 1);
    check("lw_immsrc",   32'(bus.ImmSrc),  0);
    tick();
    check("lw_memadr",   32'(bus.state),   2);
    check("lw_adr_srca", 32'(bus.ALUSrcA), 2);
    tick();
    check("lw_memread",  32'(bus.state),    3);
    check("lw_rd_adr",   32'(bus.AdrSrc),   1);
    check("lw_rd_regw",  32'(bus.RegWrite), 0);
    tick();
    check("lw_memwb",    32'(bus.state),     4);
    check("lw_wb_regw",  32'(bus.RegWrite),  1);
    check("lw_wb_res",   32'(bus.ResultSrc), 1);
    tick();
    check("lw_done", 32'(bus.state), 0);

    // sw with memory stalling three cycles
    bus.op = 7'b0100011;
    #1;
    check("sw_immsrc", 32'(bus.ImmSrc), 1);
    tick();
    tick();
    check("sw_memadr", 32'(bus.state), 2);
    tick();
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("sw_wait_state", 32'(bus.state),    5);
      check("sw_wait_memw",  32'(bus.MemWrite), 1);
      check("sw_wait_regw",  32'(bus.RegWrite), 0);
      tick();
    end
    bus.mem_ready = 1'b1;
    #1;
    check("sw_last_state", 32'(bus.state),    5);
    check("sw_last_memw",  32'(bus.MemWrite), 1);
    tick();
    check("sw_done",      32'(bus.state),    0);
    check("sw_done_memw", 32'(bus.MemWrite), 0);

    // beq taken
    bus.op   = 7'b1100011;
    bus.Zero = 1'b1;
    tick();
    check("beq_immsrc", 32'(bus.ImmSrc), 2);
    tick();
    check("beq1_state",  32'(bus.state),      9);
    check("beq1_pcw",    32'(bus.PCWrite),    1);
    check("beq1_aluctl", 32'(bus.ALUControl), 1);
    check("beq1_srca",   32'(bus.ALUSrcA),    2);
    tick();
    check("beq1_done", 32'(bus.state), 0);

    // beq not taken
    bus.Zero = 1'b0;
    tick();
    tick();
    check("beq0_state", 32'(bus.state),   9);
    check("beq0_pcw",   32'(bus.PCWrite), 0);
    tick();

    // jal
    bus.op = 7'b1101111;
    tick();
    check("jal_immsrc", 32'(bus.ImmSrc), 3);
    tick();
    check("jal_state", 32'(bus.state),   10);
    check("jal_pcw",   32'(bus.PCWrite), 1);
    check("jal_srca",  32'(bus.ALUSrcA), 1);
    check("jal_srcb",  32'(bus.ALUSrcB), 2);
    tick();
    check("jal_wb",      32'(bus.state),     8);
    check("jal_wb_regw", 32'(bus.RegWrite),  1);
    check("jal_wb_res",  32'(bus.ResultSrc), 0);
    tick();
    check("jal_done", 32'(bus.state), 0);

    // I-type or
    bus.op       = 7'b0010011;
    bus.funct3   = 3'b110;
    bus.funct7b5 = 1'b1;
    tick();
    tick();
    check("ori_state",  32'(bus.state),      7);
    check("ori_aluctl", 32'(bus.ALUControl), 3);
    check("ori_srcb",   32'(bus.ALUSrcB),    1);
    tick();
    check("ori_wb", 32'(bus.state), 8);
    tick();

    // I-type addi with bit30 set stays add
    bus.funct3 = 3'b000;
    tick();
    tick();
    check("addi_aluctl", 32'(bus.ALUControl), 0);
    tick();
    tick();

    // R-type slt
    bus.op       = 7'b0110011;
    bus.funct3   = 3'b010;
    bus.funct7b5 = 1'b0;
    tick();
    tick();
    check("slt_state",  32'(bus.state),      6);
    check("slt_aluctl", 32'(bus.ALUControl), 5);
    tick();
    tick();

    // R-type sub
    bus.funct3   = 3'b000;
    bus.funct7b5 = 1'b1;
    tick();
    tick();
    check("sub_state",  32'(bus.state),      6);
    check("sub_aluctl", 32'(bus.ALUControl), 1);
    check("sub_srcb",   32'(bus.ALUSrcB),    0);
    tick();
    tick();

    // R-type illegal funct3 traps and stays
    bus.funct3 = 3'b011;
    tick();
    tick();
    check("ill_state", 32'(bus.state),   11);
    check("ill_flag",  32'(bus.illegal), 1);
    repeat (3) tick();
    check("ill_sticky_state", 32'(bus.state),   11);
    check("ill_sticky_flag",  32'(bus.illegal), 1);
    check("ill_irwrite",      32'(bus.IRWrite), 0);
    check("ill_pcwrite",      32'(bus.PCWrite), 0);

    @(negedge clk) reset = 1'b0;
    #1;
    check("ill_rst_state", 32'(bus.state),   0);
    check("ill_rst_flag",  32'(bus.illegal), 0);
    @(negedge clk) reset = 1'b1;
    #1;
    check("ill_rel_state", 32'(bus.state), 0);

    // reset during a stalled store
    bus.op     = 7'b0100011;
    bus.funct3 = 3'b010;
    tick();
    tick();
    tick();
    bus.mem_ready = 1'b0;
    #1;
    check("swr_state", 32'(bus.state),    5);
    check("swr_memw",  32'(bus.MemWrite), 1);
    @(negedge clk) reset = 1'b0;
    #1;
    check("swr_rst_memw",  32'(bus.MemWrite), 0);
    check("swr_rst_state", 32'(bus.state),    0);
    @(negedge clk) begin
      reset         = 1'b1;
      bus.mem_ready = 1'b1;
    end
    #1;
    check("swr_rel_state",   32'(bus.state),   0);
    check("swr_rel_irwrite", 32'(bus.IRWrite), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
